// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point types and helpers for the neuron datapath stages.
// Saturation bounds here are used by fx_round_sat when NEURON_MAC_SAT_EN is defined.
package nn_fixed_pkg;

   localparam int unsigned DefBitWidth      = 32;
   localparam int unsigned DefFractionWidth = 15;

   // Wide enough for any accumulator these stages build.
   localparam int unsigned FxBoundWidth = 128;

   typedef enum logic [1:0] {
      ACCUM,
      FINAL,
      OUT
   } mac_state_t;

   function automatic logic signed [FxBoundWidth-1:0] fx_max(input int unsigned w);
      return (FxBoundWidth'(1) << (w - 1)) - FxBoundWidth'(1);
   endfunction

   function automatic logic signed [FxBoundWidth-1:0] fx_min(input int unsigned w);
      return -(FxBoundWidth'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Round-half-up, shift out FRACTION_WIDTH bits and reduce to BIT_WIDTH.
// NEURON_MAC_SAT_EN selects clipping with a sat flag; otherwise the result wraps.
module fx_round_sat
   import nn_fixed_pkg::*;
#(
   parameter int unsigned ACC_WIDTH      = 69,
   parameter int unsigned BIT_WIDTH      = DefBitWidth,
   parameter int unsigned FRACTION_WIDTH = DefFractionWidth
) (
   input  logic signed [ACC_WIDTH-1:0] acc,
   output logic        [BIT_WIDTH-1:0] value,
   output logic                        sat
);

   localparam logic signed [ACC_WIDTH-1:0] Half = ACC_WIDTH'(1) << (FRACTION_WIDTH - 1);

   logic signed [ACC_WIDTH-1:0] rounded;
   logic signed [ACC_WIDTH-1:0] shifted;
   logic                        unused_high;

   assign rounded     = acc + Half;
   assign shifted     = rounded >>> FRACTION_WIDTH;
   assign unused_high = ^shifted[ACC_WIDTH-1:BIT_WIDTH];

`ifdef NEURON_MAC_SAT_EN
   logic signed [FxBoundWidth-1:0] wide;

   assign wide = FxBoundWidth'(shifted);

   always_comb begin
      value = shifted[BIT_WIDTH-1:0];
      sat   = 1'b0;
      if (wide > fx_max(BIT_WIDTH)) begin
         value = {1'b0, {(BIT_WIDTH-1){1'b1}}};
         sat   = 1'b1;
      end else if (wide < fx_min(BIT_WIDTH)) begin
         value = {1'b1, {(BIT_WIDTH-1){1'b0}}};
         sat   = 1'b1;
      end
   end
`else
   assign value = shifted[BIT_WIDTH-1:0];
   assign sat   = 1'b0;
`endif

endmodule

// File: rtl/neuron_mac.sv
// Fixed-point neuron dot product: NUM_INPUTS (x, w) beats plus bias -> one rounded result.
// Optional output clipping with NEURON_MAC_SAT_EN (see fx_round_sat).
module neuron_mac
   import nn_fixed_pkg::*;
#(
   parameter int unsigned FRACTION_WIDTH = DefFractionWidth,
   parameter int unsigned BIT_WIDTH      = DefBitWidth,
   parameter int unsigned NUM_INPUTS     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [BIT_WIDTH-1:0] in_x,
   input  logic signed [BIT_WIDTH-1:0] in_w,
   input  logic signed [BIT_WIDTH-1:0] in_bias,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic        [BIT_WIDTH-1:0] out_val,
   output logic                        out_sat
);

   localparam int unsigned ACC_WIDTH = 2 * BIT_WIDTH + $clog2(NUM_INPUTS) + 1;
   localparam int unsigned CntWidth  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NUM_INPUTS - 1);

   mac_state_t                  state_q, state_d;
   logic        [CntWidth-1:0]  count_q, count_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic        [BIT_WIDTH-1:0] out_val_q, out_val_d;
   logic                        out_sat_q, out_sat_d;
   logic                        ready_en_q;

   logic signed [2*BIT_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]   prod_ext;
   logic signed [ACC_WIDTH-1:0]   bias_ext;
   logic        [BIT_WIDTH-1:0]   rs_val;
   logic                          rs_sat;

   assign prod     = in_x * in_w;
   assign prod_ext = ACC_WIDTH'(prod);
   assign bias_ext = ACC_WIDTH'(in_bias) <<< FRACTION_WIDTH;

   fx_round_sat #(
      .ACC_WIDTH      (ACC_WIDTH),
      .BIT_WIDTH      (BIT_WIDTH),
      .FRACTION_WIDTH (FRACTION_WIDTH)
   ) u_round_sat (
      .acc   (acc_q),
      .value (rs_val),
      .sat   (rs_sat)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      out_val_d = out_val_q;
      out_sat_d = out_sat_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ACCUM: begin
            in_ready = ready_en_q;
            if (in_valid && ready_en_q) begin
               // First beat folds in the bias, aligned to the product's Q(2*FRACTION_WIDTH).
               acc_d = (count_q == '0) ? prod_ext + bias_ext : acc_q + prod_ext;
               if (count_q == LastCnt) begin
                  count_d = '0;
                  state_d = FINAL;
               end else begin
                  count_d = count_q + CntWidth'(1);
               end
            end
         end
         FINAL: begin
            out_val_d = rs_val;
            out_sat_d = rs_sat;
            state_d   = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACCUM;
         count_q    <= '0;
         acc_q      <= '0;
         out_val_q  <= '0;
         out_sat_q  <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         out_val_q  <= out_val_d;
         out_sat_q  <= out_sat_d;
         ready_en_q <= 1'b1;
      end
   end

   assign out_val = out_val_q;
   assign out_sat = out_sat_q;

endmodule
